swipt_program_ctrl: RTL and testbench
=====================================

// Module: swipt_program_ctrl
// PURPOSE
// Top-level SWIPT phase sequencer. Steps through four phases: IDLE, frequency
// optimisation, settle/measure-current, and data/power optimisation. Drives the
// operating frequency and duty set-point into SwiptOut/DutyAdjust and gates the
// GetMeanCurrent window. Comms override and heartbeat loss pre-empt any phase.
// PARAMETERS
// FREQ_W      20         frequency word width
// DUTY_W      12         duty set-point width
// CNT_W       24         settle/measure counter width; must hold SETTLE_CYC+MEAS_CYC
// START_FREQ  20'h88B8   default frequency (35 kHz)
// START_DUTY  12'hC8     default duty set-point (200)
// DUTY_MIN    12'h32     duty lower clamp (50)
// DUTY_MAX    12'h1F4    duty upper clamp (500)
// SETTLE_CYC  5000000    cycles in phase 10 before the measure window opens
// MEAS_CYC    2000000    cycles measure is held high in phase 10
// PORTS
// clk            in   1       system clock
// nrst           in   1       asynchronous reset, active low
// swipt_alive    in   1       heartbeat-valid from Heartbeat
// comms_ctrl     in   1       comms override enable
// comms_freq     in   FREQ_W  override frequency
// comms_duty     in   DUTY_W  override duty
// freq_alg_done  in   1       Freq search finished
// new_freq       in   FREQ_W  Freq candidate under test
// best_freq      in   FREQ_W  Freq search result
// mean_req       in   1       Data block's request for a mean-current window
// duty_rdy       in   1       one-cycle strobe: duty step requested
// duty_dn        in   1       step direction, sampled with duty_rdy (1=down, 0=up)
// program        out  2       phase: 00 IDLE, 01 FREQ, 10 MEAS, 11 DATA
// freq           out  FREQ_W  operating frequency
// duty           out  DUTY_W  duty set-point (feeds DutyAdjust l)
// measure        out  1       GetMeanCurrent window enable
// BEHAVIOUR
// - All outputs are registered. nrst low (async) sets: program=00, freq=START_FREQ,
//   duty=START_DUTY, measure=0, cnt=SETTLE_CYC+MEAS_CYC.
// - Per-cycle priority: (1) swipt_alive=0 -> same values as reset, applied at the
//   next edge. (2) comms_ctrl=1 -> freq<=comms_freq, duty<=comms_duty (no clamp),
//   program<=00, measure<=0, cnt reloaded. (3) Otherwise, the phase FSM runs.
// - 00 IDLE: program<=01 on the next edge.
// - 01 FREQ: if freq_alg_done=0, freq<=new_freq every cycle. Otherwise freq<=best_freq
//   and program<=10.
// - 10 MEAS: if cnt==0, then program<=11, measure<=0, and cnt is reloaded. Otherwise
//   cnt decrements, and measure<=(cnt<=MEAS_CYC). This gives exactly MEAS_CYC
//   high cycles after SETTLE_CYC low cycles. Phase dwell is SETTLE_CYC+MEAS_CYC+1.
// - 11 DATA: measure<=mean_req (1-cycle latency). Stays in 11 until abort or
//   override. On duty_rdy, step=duty/10 (integer floor):
//   up:   duty<=(duty+step < DUTY_MAX) ? duty+step : DUTY_MAX
//   down: duty<=(duty-step > DUTY_MIN) ? duty-step : DUTY_MIN
//   Sums and differences are computed in DUTY_W+1 bits, so there is no wrap.
//   Duty updates one cycle after duty_rdy. Back-to-back strobes each apply
//   to the previous result.
// - duty_rdy and mean_req are ignored outside phase 11. freq_alg_done is ignored
//   outside phase 01.
// - An abort or override mid-phase discards progress; the next run restarts at 00
//   with a full cnt reload.
// TESTING
// - Reset hold, then release with swipt_alive=1 -> program=00,
//   freq=0x88B8, duty=200, measure=0.
// - Short sequence (SETTLE_CYC=5, MEAS_CYC=3): new_freq sweeps, then done with
//   best_freq=0x9000 -> freq=0x9000. measure is high 3 cycles after 5 low, then
//   program=11.
// - In 11 with duty=200, one up strobe -> duty=220. With duty=480, up -> 500
//   (clamp). With duty=55, down -> 50 (clamp).
// - comms_ctrl=1 mid-MEAS with comms_freq=0x7530, comms_duty=300 -> next cycle
//   program=00, measure=0, freq=0x7530, duty=300.
// - swipt_alive drops in 11 with duty=330 -> next cycle program=00, duty=200,
//   freq=0x88B8. On recovery, the full sequence reruns.
// - Async nrst assertion mid-measure-window -> measure=0 immediately, with no clock edge.

Source files
------------

// File: rtl/swipt_program_ctrl.sv
// swipt_program_ctrl: SWIPT phase sequencer driving frequency, duty set-point and mean-current window
// The phase output is named prog because "program" is a reserved SystemVerilog keyword.
module swipt_program_ctrl #(
    parameter int                 FREQ_W     = 20,
    parameter int                 DUTY_W     = 12,
    parameter int                 CNT_W      = 24,
    parameter logic [FREQ_W-1:0]  START_FREQ = 20'h88B8,
    parameter logic [DUTY_W-1:0]  START_DUTY = 12'hC8,
    parameter logic [DUTY_W-1:0]  DUTY_MIN   = 12'h32,
    parameter logic [DUTY_W-1:0]  DUTY_MAX   = 12'h1F4,
    parameter int                 SETTLE_CYC = 5000000,
    parameter int                 MEAS_CYC   = 2000000
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              swipt_alive,
    input  logic              comms_ctrl,
    input  logic [FREQ_W-1:0] comms_freq,
    input  logic [DUTY_W-1:0] comms_duty,
    input  logic              freq_alg_done,
    input  logic [FREQ_W-1:0] new_freq,
    input  logic [FREQ_W-1:0] best_freq,
    input  logic              mean_req,
    input  logic              duty_rdy,
    input  logic              duty_dn,
    output logic [1:0]        prog,
    output logic [FREQ_W-1:0] freq,
    output logic [DUTY_W-1:0] duty,
    output logic              measure
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] FREQ = 2'b01;
    localparam logic [1:0] MEAS = 2'b10;
    localparam logic [1:0] DATA = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC + MEAS_CYC);
    localparam logic [CNT_W-1:0] MEAS_LIM = CNT_W'(MEAS_CYC);

    logic [1:0]        prog_q, prog_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              measure_q, measure_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              abort;
    logic              meas_end;
    logic [DUTY_W-1:0] step;
    logic [DUTY_W:0]   duty_sum;
    logic [DUTY_W:0]   duty_dif;
    logic [DUTY_W-1:0] duty_up;
    logic [DUTY_W-1:0] duty_down;

    assign abort     = !swipt_alive || comms_ctrl;
    assign meas_end  = (prog_q == MEAS) && (cnt_q == '0);
    assign step      = duty_q / DUTY_W'(10);
    assign duty_sum  = {1'b0, duty_q} + {1'b0, step};
    assign duty_dif  = {1'b0, duty_q} - {1'b0, step};
    assign duty_up   = (duty_sum < {1'b0, DUTY_MAX}) ? duty_sum[DUTY_W-1:0] : DUTY_MAX;
    assign duty_down = (duty_dif > {1'b0, DUTY_MIN}) ? duty_dif[DUTY_W-1:0] : DUTY_MIN;

    // State register: every output is a flop; async reset returns to the idle defaults
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prog_q    <= IDLE;
            freq_q    <= START_FREQ;
            duty_q    <= START_DUTY;
            measure_q <= 1'b0;
            cnt_q     <= CNT_LOAD;
        end else begin
            prog_q    <= prog_d;
            freq_q    <= freq_d;
            duty_q    <= duty_d;
            measure_q <= measure_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next phase and settle/measure counter; abort or override restarts from idle with a full reload
    always_comb begin
        prog_d = abort                                 ? IDLE :
                 (prog_q == IDLE)                      ? FREQ :
                 (prog_q == FREQ && freq_alg_done)     ? MEAS :
                 meas_end                              ? DATA : prog_q;
        cnt_d  = (abort || meas_end) ? CNT_LOAD :
                 (prog_q == MEAS)    ? cnt_q - 1'b1 : cnt_q;
    end

    // Frequency, duty and measure-window outputs for the coming cycle
    always_comb begin
        freq_d    = !swipt_alive                   ? START_FREQ :
                    comms_ctrl                     ? comms_freq :
                    (prog_q == FREQ)               ? (freq_alg_done ? best_freq : new_freq) : freq_q;
        duty_d    = !swipt_alive                   ? START_DUTY :
                    comms_ctrl                     ? comms_duty :
                    (prog_q == DATA && duty_rdy)   ? (duty_dn ? duty_down : duty_up) : duty_q;
        measure_d = abort                          ? 1'b0 :
                    (prog_q == MEAS)               ? (cnt_q != '0 && cnt_q <= MEAS_LIM) :
                    (prog_q == DATA)               ? mean_req : 1'b0;
    end

    assign prog    = prog_q;
    assign freq    = freq_q;
    assign duty    = duty_q;
    assign measure = measure_q;
endmodule

// File: tb/tb_swipt_program_ctrl.sv
// tb_swipt_program_ctrl: scoreboard bench for the SWIPT phase sequencer with short settle/measure counts
module tb_swipt_program_ctrl;
    localparam int S = 5;
    localparam int M = 3;

    typedef struct {
        int p;
        int f;
        int d;
        int m;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        swipt_alive = 1'b1;
    logic        comms_ctrl = 1'b0;
    logic [19:0] comms_freq = '0;
    logic [11:0] comms_duty = '0;
    logic        freq_alg_done = 1'b0;
    logic [19:0] new_freq = '0;
    logic [19:0] best_freq = '0;
    logic        mean_req = 1'b0;
    logic        duty_rdy = 1'b0;
    logic        duty_dn = 1'b0;
    logic [1:0]  prog;
    logic [19:0] freq;
    logic [11:0] duty;
    logic        measure;

    int   n_run = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   m_p, m_f, m_d, m_m, m_c;
    int   dwell, hi;

    always #5 clk = ~clk;

    swipt_program_ctrl #(.SETTLE_CYC(S), .MEAS_CYC(M)) dut (
        .clk(clk), .nrst(nrst), .swipt_alive(swipt_alive), .comms_ctrl(comms_ctrl),
        .comms_freq(comms_freq), .comms_duty(comms_duty), .freq_alg_done(freq_alg_done),
        .new_freq(new_freq), .best_freq(best_freq), .mean_req(mean_req),
        .duty_rdy(duty_rdy), .duty_dn(duty_dn), .prog(prog), .freq(freq),
        .duty(duty), .measure(measure)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_p = 0; m_f = 'h88B8; m_d = 200; m_m = 0; m_c = S + M;
    endtask

    // Behavioural reference: what the outputs must be after the next edge, given current inputs
    task automatic model_step();
        int s;
        if (!swipt_alive) model_reset();
        else if (comms_ctrl) begin
            m_p = 0; m_f = int'(comms_freq); m_d = int'(comms_duty); m_m = 0; m_c = S + M;
        end else begin
            case (m_p)
                0: begin m_p = 1; m_m = 0; end
                1: begin
                    m_m = 0;
                    if (freq_alg_done) begin m_f = int'(best_freq); m_p = 2; end
                    else m_f = int'(new_freq);
                end
                2: if (m_c == 0) begin m_p = 3; m_m = 0; m_c = S + M; end
                   else begin m_m = (m_c <= M) ? 1 : 0; m_c--; end
                default: begin
                    m_m = int'(mean_req);
                    if (duty_rdy) begin
                        s = m_d / 10;
                        if (duty_dn) m_d = (m_d - s > 50) ? m_d - s : 50;
                        else m_d = (m_d + s < 500) ? m_d + s : 500;
                    end
                end
            endcase
        end
    endtask

    task automatic cyc();
        exp_t e;
        model_step();
        sb.push_back('{m_p, m_f, m_d, m_m});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("prog", 32'(prog), e.p);
        check("freq", 32'(freq), e.f);
        check("duty", 32'(duty), e.d);
        check("measure", 32'(measure), e.m);
    endtask

    task automatic to_meas();
        cyc();
        best_freq = 20'h9000;
        freq_alg_done = 1'b1;
        cyc();
        freq_alg_done = 1'b0;
        check("freq_best", 32'(freq), 32'h9000);
        check("prog_meas", 32'(prog), 2);
    endtask

    task automatic finish_meas(output int dw, output int h);
        dw = 1;
        h = int'(measure);
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (prog != 2'b10) break;
            dw++;
            h += int'(measure);
        end
        check("prog_data", 32'(prog), 3);
        check("meas_dwell", 32'(dw), S + M + 1);
        check("meas_high", 32'(h), M);
    endtask

    task automatic load_via_comms(input logic [11:0] d, input logic [19:0] f);
        comms_freq = f;
        comms_duty = d;
        comms_ctrl = 1'b1;
        cyc();
        comms_ctrl = 1'b0;
        check("comms_duty", 32'(duty), 32'(d));
        check("comms_prog", 32'(prog), 0);
    endtask

    task automatic strobe(input logic dn);
        duty_dn = dn;
        duty_rdy = 1'b1;
        cyc();
        duty_rdy = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_prog", 32'(prog), 0);
        check("rst_freq", 32'(freq), 32'h88B8);
        check("rst_duty", 32'(duty), 200);
        check("rst_measure", 32'(measure), 0);
        @(negedge clk);
        nrst = 1'b1;
        model_reset();
        #1;
        check("rel_prog", 32'(prog), 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            new_freq = 20'h8000 + 20'(i * 'h400);
            cyc();
            check("freq_sweep", 32'(freq), 32'(new_freq));
        end
        best_freq = 20'h9000;
        freq_alg_done = 1'b1;
        cyc();
        freq_alg_done = 1'b0;
        check("freq_best", 32'(freq), 32'h9000);
        finish_meas(dwell, hi);
        mean_req = 1'b1;
        cyc();
        check("mean_win_on", 32'(measure), 1);
        mean_req = 1'b0;
        cyc();
        check("mean_win_off", 32'(measure), 0);
        strobe(1'b0);
        check("duty_up", 32'(duty), 220);

        load_via_comms(12'd200, 20'h8000);
        to_meas();
        duty_rdy = 1'b1;
        cyc();
        duty_rdy = 1'b0;
        repeat (4) cyc();
        comms_freq = 20'h7530;
        comms_duty = 12'd300;
        comms_ctrl = 1'b1;
        cyc();
        comms_ctrl = 1'b0;
        check("ovr_prog", 32'(prog), 0);
        check("ovr_measure", 32'(measure), 0);
        check("ovr_freq", 32'(freq), 32'h7530);
        check("ovr_duty", 32'(duty), 300);

        to_meas();
        finish_meas(dwell, hi);
        strobe(1'b0);
        check("duty_330", 32'(duty), 330);
        swipt_alive = 1'b0;
        cyc();
        swipt_alive = 1'b1;
        check("loss_prog", 32'(prog), 0);
        check("loss_duty", 32'(duty), 200);
        check("loss_freq", 32'(freq), 32'h88B8);
        to_meas();
        finish_meas(dwell, hi);

        load_via_comms(12'd480, 20'h8800);
        to_meas();
        finish_meas(dwell, hi);
        strobe(1'b0);
        check("duty_clamp_hi", 32'(duty), 500);
        load_via_comms(12'd55, 20'h8800);
        to_meas();
        finish_meas(dwell, hi);
        strobe(1'b1);
        check("duty_clamp_lo", 32'(duty), 50);

        load_via_comms(12'd200, 20'h8800);
        to_meas();
        for (int i = 0; i < 20; i++) begin
            if (measure) break;
            cyc();
        end
        check("meas_window", 32'(measure), 1);
        #2;
        nrst = 1'b0;
        #1;
        check("async_measure", 32'(measure), 0);
        check("async_prog", 32'(prog), 0);
        check("async_freq", 32'(freq), 32'h88B8);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        cyc();
        check("restart_prog", 32'(prog), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
